// File: rtl/boruss_pkg.sv
// Shared opcode, field, flag and state definitions for the boruss control unit.
package boruss_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FLG_W   = 3;
    localparam int unsigned REG_AW  = 2;
    localparam int unsigned NREGS   = 4;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_NOT = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;
    localparam logic [7:0] OP_JMP = 8'h08;
    localparam logic [7:0] OP_JZ  = 8'h09;
    localparam logic [7:0] OP_JC  = 8'h0A;
    localparam logic [7:0] OP_CMP = 8'h0F;
    localparam logic [7:0] OP_LDI = 8'h10;
    localparam logic [7:0] OP_HLT = 8'hFE;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 0;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 8;
    localparam int unsigned OPND_MSB = 7;
    localparam int unsigned OPND_LSB = 0;
    localparam int unsigned RD_MSB   = 3;
    localparam int unsigned RD_LSB   = 2;
    localparam int unsigned RS_MSB   = 1;
    localparam int unsigned RS_LSB   = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_IMM,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    // Unary ALU ops take only operand_a; operand_b is forced to zero for them.
    function automatic logic ignores_rs(input logic [7:0] op);
        return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/boruss_regfile.sv
// 4x8 register file: two async read ports, async debug port, one sync write port.
module boruss_regfile
    import boruss_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/boruss_control_unit.sv
// Fetch/decode/execute/writeback sequencer driving boruss_alu from a 4x8 register file.
// Optional conditional branches (JZ/JC) are enabled by defining BORUSS_CU_COND_JUMP_EN.
module boruss_control_unit
    import boruss_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [DATA_W-1:0]  alu_operand_a,
    output logic [DATA_W-1:0]  alu_operand_b,
    output logic [DATA_W-1:0]  alu_operation_code,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_negative,
    output logic [FLG_W-1:0]   flags_q,
    output logic               halted,
    output logic               illegal_op,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t              state;
    state_t              state_nx;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   res_q;
    logic [FLG_W-1:0]    flg_q;
    logic [PC_W-1:0]     pc;

    logic [7:0]          opc;
    logic [DATA_W-1:0]   opnd;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic                is_alu, is_cmp, is_jmp, is_cjmp, is_ldi, is_hlt, is_legal;
    logic                cjmp_taken;
    logic                fetch_ok;
    logic                req_nx;

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   ra_data;
    logic [DATA_W-1:0]   rb_data;

    assign opc       = ir[OPC_MSB:OPC_LSB];
    assign opnd      = ir[OPND_MSB:OPND_LSB];
    assign rd        = ir[RD_MSB:RD_LSB];
    assign rs        = ir[RS_MSB:RS_LSB];
    assign imem_addr = pc;
    assign fetch_ok  = imem_req && imem_valid;

    boruss_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (rf_wdata),
        .ra_addr  (rd),
        .ra_data  (ra_data),
        .rb_addr  (rs),
        .rb_data  (rb_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // Instruction class decode from the held instruction register.
    always_comb begin
        is_alu     = 1'b0;
        is_cmp     = (opc == OP_CMP);
        is_jmp     = (opc == OP_JMP);
        is_ldi     = (opc == OP_LDI);
        is_hlt     = (opc == OP_HLT);
        is_cjmp    = 1'b0;
        cjmp_taken = 1'b0;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: is_alu = 1'b1;
            default: ;
        endcase
`ifdef BORUSS_CU_COND_JUMP_EN
        is_cjmp    = (opc == OP_JZ) || (opc == OP_JC);
        cjmp_taken = ((opc == OP_JZ) && flags_q[FLG_Z]) || ((opc == OP_JC) && flags_q[FLG_C]);
`endif
        is_legal   = is_alu || is_cmp || is_jmp || is_cjmp || is_ldi || is_hlt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, fetch request and register-file write controls.
    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        rf_wdata = res_q;
        case (state)
            S_FETCH:     if (fetch_ok) state_nx = S_DECODE;
            S_DECODE: begin
                if (!is_legal || is_hlt) state_nx = S_HALT;
                else if (is_ldi)         state_nx = S_FETCH_IMM;
                else                     state_nx = S_EXECUTE;
            end
            S_FETCH_IMM: if (fetch_ok) state_nx = S_WRITEBACK;
            S_EXECUTE:   state_nx = S_WRITEBACK;
            S_WRITEBACK: begin
                state_nx = S_FETCH;
                rf_we    = is_alu || is_ldi;
                rf_wdata = is_ldi ? imm : res_q;
            end
            S_HALT:      state_nx = S_HALT;
            default:     state_nx = S_HALT;
        endcase
        req_nx = (state_nx == S_FETCH) || (state_nx == S_FETCH_IMM);
    end

    // ALU inputs load on the DECODE->EXECUTE edge so the result is settled during EXECUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                 <= RESET_PC;
            ir                 <= '0;
            imm                <= '0;
            res_q              <= '0;
            flg_q              <= '0;
            flags_q            <= '0;
            halted             <= 1'b0;
            illegal_op         <= 1'b0;
            imem_req           <= 1'b0;
            alu_operand_a      <= '0;
            alu_operand_b      <= '0;
            alu_operation_code <= '0;
        end else begin
            imem_req <= req_nx;
            case (state)
                S_FETCH: begin
                    if (fetch_ok) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_FETCH_IMM: begin
                    if (fetch_ok) begin
                        imm <= imem_rdata[OPND_MSB:OPND_LSB];
                        pc  <= pc + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    if (state_nx == S_HALT) begin
                        halted <= 1'b1;
                        if (!is_legal) illegal_op <= 1'b1;
                    end
                    if (state_nx == S_EXECUTE) begin
                        if (is_jmp || is_cjmp) begin
                            alu_operation_code <= OP_JMP;
                            alu_operand_a      <= '0;
                            alu_operand_b      <= opnd;
                        end else begin
                            alu_operation_code <= opc;
                            alu_operand_a      <= ra_data;
                            alu_operand_b      <= ignores_rs(opc) ? '0 : rb_data;
                        end
                    end
                end
                S_EXECUTE: begin
                    res_q        <= alu_result;
                    flg_q[FLG_Z] <= alu_zero;
                    flg_q[FLG_C] <= alu_carry;
                    flg_q[FLG_N] <= alu_negative;
                end
                S_WRITEBACK: begin
                    if (is_alu || is_cmp) flags_q <= flg_q;
                    if (is_jmp || cjmp_taken) pc <= PC_W'(res_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boruss_control_unit.sv
// Randomized + directed bench for boruss_control_unit with behavioural ALU, imem and ISA model.
module tb_boruss_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [7:0]  alu_operand_a, alu_operand_b, alu_operation_code, alu_result;
    logic        alu_zero, alu_carry, alu_negative;
    logic [2:0]  flags_q;
    logic        halted, illegal_op;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    boruss_control_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_operation_code(alu_operation_code), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .flags_q(flags_q), .halted(halted), .illegal_op(illegal_op),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {Z,C,N,result}; SUB/CMP carry means borrow.
    function automatic logic [10:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            8'h00: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
            8'h01, 8'h0F: begin r = a - b; c = (a < b); end
            8'h02: r = a & b;
            8'h03: r = a | b;
            8'h04: r = a ^ b;
            8'h05: r = ~a;
            8'h06: begin r = {a[6:0], 1'b0}; c = a[7]; end
            8'h07: begin r = {1'b0, a[7:1]}; c = a[0]; end
            8'h08: r = b;
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), c, r[7], r};
    endfunction

    always_comb {alu_zero, alu_carry, alu_negative, alu_result} = alu_f(alu_operation_code, alu_operand_a, alu_operand_b);

    // Behavioural imem with programmable wait states and stray valid while idle.
    logic [15:0] m [256];
    int          wait_n = 0;
    int          wcnt = 0;
    logic        noise = 1'b0;
    int          cyc = 0;

    assign imem_rdata = m[imem_addr];
    assign imem_valid = imem_req ? (wcnt >= wait_n) : noise;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= 1'($urandom);
        if (rst || !imem_req || imem_valid) wcnt <= 0;
        else                                wcnt <= wcnt + 1;
    end

    logic [7:0] acc_addr [$];
    int         acc_cyc  [$];
    always @(posedge clk) begin
        if (!rst && imem_req && imem_valid) begin
            acc_addr.push_back(imem_addr);
            acc_cyc.push_back(cyc);
        end
    end

    // Request/address must hold while a fetch is waiting; record halt time.
    logic       prev_req = 1'b0, prev_valid = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int         stab_err = 0;
    bit         halt_seen = 1'b0;
    int         halt_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (prev_req && !prev_valid && (!imem_req || imem_addr != prev_addr)) stab_err++;
            if (halted && !halt_seen) begin
                halt_seen = 1'b1;
                halt_cyc  = cyc - 1;
            end
            prev_req   = imem_req;
            prev_valid = imem_valid;
            prev_addr  = imem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input int i, output logic [7:0] v);
        dbg_sel = 2'(i);
        #1;
        v = dbg_data;
    endtask

    // ISA-level reference: architectural effect of each instruction plus fetch schedule.
    logic [7:0] exp_addr  [$];
    int         exp_delta [$];
    logic [7:0] mr [4];
    logic [2:0] mflags;
    bit         millegal;

    task automatic run_model();
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  op;
        logic [10:0] o;
        int          nextd;
        bit          done;
        pc = 8'h00; nextd = 0; done = 1'b0;
        mflags = 3'b000; millegal = 1'b0;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        exp_addr.delete();
        exp_delta.delete();
        for (int step = 0; step < 600 && !done; step++) begin
            exp_addr.push_back(pc);
            exp_delta.push_back(nextd);
            ir = m[pc];
            pc = pc + 8'd1;
            op = ir[15:8];
            nextd = 4;
            case (op)
                8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07: begin
                    o = alu_f(op, mr[ir[3:2]], mr[ir[1:0]]);
                    mr[ir[3:2]] = o[7:0];
                    mflags = o[10:8];
                end
                8'h0F: begin
                    o = alu_f(op, mr[ir[3:2]], mr[ir[1:0]]);
                    mflags = o[10:8];
                end
                8'h08: pc = ir[7:0];
                8'h10: begin
                    exp_addr.push_back(pc);
                    exp_delta.push_back(2);
                    mr[ir[3:2]] = m[pc][7:0];
                    pc = pc + 8'd1;
                    nextd = 2;
                end
                8'hFE: done = 1'b1;
`ifdef BORUSS_CU_COND_JUMP_EN
                8'h09: if (mflags[2]) pc = ir[7:0];
                8'h0A: if (mflags[1]) pc = ir[7:0];
`endif
                default: begin done = 1'b1; millegal = 1'b1; end
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        acc_addr.delete();
        acc_cyc.delete();
        halt_seen = 1'b0;
        stab_err  = 0;
        rst = 1'b0;
    endtask

    task automatic fill_hlt();
        for (int i = 0; i < 256; i++) m[i] = 16'hFE00;
    endtask

    task automatic run_case(input string tag, input int w);
        bit         ok;
        int         nerr, n;
        logic [7:0] v;
        wait_n = w;
        run_model();
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (halted) ok = 1'b1;
        end
        chk({tag, ".halted"}, 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, ".req_idle"}, 32'(imem_req), 32'd0);
        chk({tag, ".illegal"}, 32'(illegal_op), 32'(millegal));
        chk({tag, ".flags"}, 32'(flags_q), 32'(mflags));
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            chk($sformatf("%s.r%0d", tag, i), 32'(v), 32'(mr[i]));
        end
        chk({tag, ".nfetch"}, 32'(acc_addr.size()), 32'(exp_addr.size()));
        nerr = 0;
        n = (acc_addr.size() < exp_addr.size()) ? acc_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (acc_addr[i] !== exp_addr[i]) nerr++;
            if (i > 0 && (acc_cyc[i] - acc_cyc[i-1]) != exp_delta[i] + w) nerr++;
        end
        chk({tag, ".trace"}, 32'(nerr), 32'd0);
        if (acc_cyc.size() > 0) chk({tag, ".halt_lat"}, 32'(halt_cyc - acc_cyc[$]), 32'd1);
        chk({tag, ".req_stable"}, 32'(stab_err), 32'd0);
    endtask

    task automatic gen_prog();
        int L, i, k, tgt;
        logic [7:0] op;
        fill_hlt();
        L = $urandom_range(6, 20);
        i = 0;
        while (i < L) begin
            k = $urandom_range(0, 11);
            tgt = $urandom_range(i + 1, L + 1);
            if (k <= 5) begin
                op = 8'($urandom_range(0, 8));
                if (op == 8'h08) op = 8'h0F;
                m[i] = {op, 8'($urandom)};
                i++;
            end else if (k <= 8) begin
                m[i]   = {8'h10, 8'($urandom)};
                m[i+1] = {8'hFE, 8'($urandom)};
                i += 2;
            end else if (k == 9) begin
                m[i] = {8'h08, 8'(tgt)};
                i++;
            end else if (k == 10) begin
                m[i] = {($urandom_range(0, 1) != 0) ? 8'h09 : 8'h0A, 8'(tgt)};
                i++;
            end else begin
                m[i] = ($urandom_range(0, 3) == 0) ? 16'h5500 : {8'h01, 8'($urandom)};
                i++;
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        bit         ok;
        fill_hlt();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", 32'(imem_addr), 32'd0);
        chk("rst.flags", 32'(flags_q), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.illegal", 32'(illegal_op), 32'd0);
        chk("rst.alu_in", {8'h00, alu_operand_a, alu_operand_b, alu_operation_code}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            chk($sformatf("rst.r%0d", i), 32'(v), 32'd0);
        end

        // LDI r1,0A; LDI r2,05; ADD r1,r2; HLT
        fill_hlt();
        m[0] = 16'h1004; m[1] = 16'h000A; m[2] = 16'h1008; m[3] = 16'h0005; m[4] = 16'h0006;
        for (int w = 0; w < 4; w += 3) begin
            run_case($sformatf("add_w%0d", w), w);
            read_reg(1, v);
            chk($sformatf("add_w%0d.r1_const", w), 32'(v), 32'h0F);
            chk($sformatf("add_w%0d.flags_const", w), 32'(flags_q), 32'b000);
        end

        // LDI r0,FF; LDI r1,01; ADD r0,r1 then CMP r0,r0
        fill_hlt();
        m[0] = 16'h1000; m[1] = 16'h00FF; m[2] = 16'h1004; m[3] = 16'h0001; m[4] = 16'h0001;
        run_case("carry", 0);
        read_reg(0, v);
        chk("carry.r0_const", 32'(v), 32'h00);
        chk("carry.flags_const", 32'(flags_q), 32'b110);
        m[5] = 16'h0F00;
        run_case("cmp", 1);
        chk("cmp.flags_const", 32'(flags_q), 32'b100);

        // JMP 40
        fill_hlt();
        m[0] = 16'h0840;
        run_case("jmp", 0);
        if (acc_addr.size() > 1) chk("jmp.target", 32'(acc_addr[1]), 32'h40);
        else                     chk("jmp.target_seen", 32'(acc_addr.size()), 32'd2);

        // PC wrap: imm fetched from FF -> 00, next op at 01
        fill_hlt();
        m[8'h00] = 16'h08FC; m[8'hFC] = 16'h1000; m[8'hFD] = 16'hFE80;
        m[8'hFE] = 16'h0101; m[8'hFF] = 16'h1004;
        run_case("wrap", 2);

        // Illegal opcode
        fill_hlt();
        m[0] = 16'h5500;
        run_case("illegal", 0);
        chk("illegal.const", 32'(illegal_op), 32'd1);

        // SUB r0,r0; JZ 20
        fill_hlt();
        m[0] = 16'h0100; m[1] = 16'h0920;
        run_case("jz", 0);
`ifdef BORUSS_CU_COND_JUMP_EN
        chk("jz.illegal_const", 32'(illegal_op), 32'd0);
        if (acc_addr.size() > 2) chk("jz.target", 32'(acc_addr[2]), 32'h20);
        else                     chk("jz.target_seen", 32'(acc_addr.size()), 32'd3);
`else
        chk("jz.illegal_const", 32'(illegal_op), 32'd1);
`endif

        // Reset asserted mid-FETCH_IMM
        fill_hlt();
        m[0] = 16'h1004; m[1] = 16'hFE0A; m[2] = 16'h1008; m[3] = 16'hFE05;
        wait_n = 3;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (acc_addr.size() >= 3 && imem_req) ok = 1'b1;
        end
        chk("midrst.reached", 32'(ok), 32'd1);
        chk("midrst.addr_pre", 32'(imem_addr), 32'h03);
        read_reg(1, v);
        chk("midrst.r1_pre", 32'(v), 32'h0A);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.req", 32'(imem_req), 32'd0);
        chk("midrst.pc", 32'(imem_addr), 32'h00);
        read_reg(1, v);
        chk("midrst.r1", 32'(v), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Randomized programs
        for (int t = 0; t < 20; t++) begin
            gen_prog();
            run_case($sformatf("rnd%0d", t), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
